// File: rtl/mul32_seq.sv
// Iterative 32x32 shift-add multiplier built around cla_adder32, one partial product per cycle.
// Optional signed mode is compiled in with `define MUL_SIGNED_EN (adds sgn port and NEG state).

module cla_adder32 (
    output logic        cout,
    output logic [31:0] sum,
    input  logic [31:0] a,
    input  logic [31:0] b
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit lookahead groups; group carries chain between groups
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        c     = '0;
        for (int j = 0; j < 8; j++) begin
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j] = &p[4*j +: 4];
        end
        for (int j = 0; j < 8; j++) begin
            c[4*j+1] = g[4*j]   | (p[4*j]   & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = grp_g[j] | (grp_p[j] & c[4*j]);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

// state  | meaning
// S_IDLE | waiting for start; product holds last result
// S_RUN  | one shift-add step per cycle, 32 steps
// S_NEG  | (signed build) conditional 64-bit negate of the accumulator
// S_DONE | product register loads {hi,lo}; done pulses next cycle
module mul32_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef MUL_SIGNED_EN
    input  logic               sgn,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [4:0]       count;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;
`ifdef MUL_SIGNED_EN
    logic             neg_flag;
    logic [2*WIDTH-1:0] acc_neg;

    // magnitude conversion; 0x80000000 stays 0x80000000, i.e. 2^31 unsigned
    assign a_cap   = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_cap   = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign acc_neg = ~{hi, lo} + 1'b1;
`else
    assign a_cap = a;
    assign b_cap = b;
`endif

    assign add_b = lo[0] ? mcand : '0;
    assign busy  = (state == S_RUN);

    cla_adder32 u_add (
        .cout (add_cout),
        .sum  (add_sum),
        .a    (hi),
        .b    (add_b)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (count == 5'd31) begin
`ifdef MUL_SIGNED_EN
                    state_nxt = S_NEG;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_NEG:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            product  <= '0;
            done     <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_flag <= 1'b0;
`endif
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= a_cap;
                        lo    <= b_cap;
                        hi    <= '0;
                        count <= '0;
`ifdef MUL_SIGNED_EN
                        neg_flag <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                    end
                end
                S_RUN: begin
                    {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                    count    <= count + 5'd1;
                end
                S_NEG: begin
`ifdef MUL_SIGNED_EN
                    if (neg_flag) {hi, lo} <= acc_neg;
`endif
                end
                S_DONE:  product <= {hi, lo};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed cases plus random operands against an arithmetic model.
module tb_mul32_seq;
`ifdef MUL_SIGNED_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn_r;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_prod;

    always #5 clk = ~clk;

    mul32_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef MUL_SIGNED_EN
        .sgn     (sgn_r),
`endif
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx;
        longint sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Called at #1 after an edge; start is held for exactly one edge. A stray start pulse
    // with other operands is injected before edge N+glitch_at (0 = none).
    task automatic run_mul(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                           input int glitch_at);
        logic [63:0] exp;
        exp   = model(ta, tb, ts);
        a     = ta;
        b     = tb;
        sgn_r = ts;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_rise", {63'd0, busy}, 64'd1);
        chk("done_low", {63'd0, done}, 64'd0);
        chk("prod_hold", product, last_prod);
        for (int k = 1; k <= LAT; k++) begin
            if (k == glitch_at) begin
                a     = $urandom;
                b     = $urandom;
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("busy", {63'd0, busy}, (k <= 31) ? 64'd1 : 64'd0);
            chk("done", {63'd0, done}, (k == LAT) ? 64'd1 : 64'd0);
            chk("product", product, (k == LAT) ? exp : last_prod);
        end
        last_prod = exp;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", {63'd0, busy}, 64'd0);
            chk("idle_done", {63'd0, done}, 64'd0);
            chk("idle_prod", product, last_prod);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        sgn_r     = 1'b0;
        a         = 32'd3;
        b         = 32'd5;
        last_prod = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_prod", product, 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        run_mul(32'd3, 32'd5, 1'b0, 0);
        idle_cycles(1);
        chk("t1_prod", product, 64'h0000_0000_0000_000F);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        chk("t2_prod", product, 64'hFFFF_FFFE_0000_0001);
        idle_cycles(1);

        run_mul(32'd7, 32'd9, 1'b0, 5);
        chk("t3_prod", product, 64'd63);
        run_mul(32'd2, 32'd2, 1'b0, LAT);
        chk("t3_b2b", product, 64'd4);
        idle_cycles(2);

        // reset partway through RUN, with start also high to confirm reset priority
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_busy_mid", {63'd0, busy}, 64'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_done", {63'd0, done}, 64'd0);
        chk("t4_prod", product, 64'd0);
        last_prod = 64'd0;
        idle_cycles(1);
        run_mul(32'd0, 32'h1234_5678, 1'b0, 0);
        chk("t4_zero", product, 64'd0);

`ifdef MUL_SIGNED_EN
        run_mul(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 0);
        chk("t5_neg", product, 64'hFFFF_FFFF_FFFF_FFFE);
        run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        chk("t5_min", product, 64'h4000_0000_0000_0000);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        chk("t5_m1", product, 64'd1);
        run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        chk("t6_uns", product, 64'h0000_0001_FFFF_FFFE);
`endif

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                default: ;
            endcase
`ifdef MUL_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_mul(ra, rb, rs, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT)) : 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
